// File: rtl/junction_phase_sequencer.sv
// Four-way actuated traffic phase sequencer: round-robin green/yellow/all-red
// grants driven by latched presence requests and a prescaled TICK time base.
module junction_phase_sequencer #(
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned GREEN_MAX = 40,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       TICK,
  input  logic [3:0] REQ,
  output logic       N_RedLight,
  output logic       N_YellowLight,
  output logic       N_GreenLight,
  output logic       E_RedLight,
  output logic       E_YellowLight,
  output logic       E_GreenLight,
  output logic       S_RedLight,
  output logic       S_YellowLight,
  output logic       S_GreenLight,
  output logic       W_RedLight,
  output logic       W_YellowLight,
  output logic       W_GreenLight,
  output logic [1:0] PHASE,
  output logic       GREEN_START,
  output logic [1:0] STATE_DBG
);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2
  } phaseState_t;

  localparam logic [CNT_W:0] G_MIN = (CNT_W + 1)'(GREEN_MIN);
  localparam logic [CNT_W:0] G_MAX = (CNT_W + 1)'(GREEN_MAX);
  localparam logic [CNT_W:0] Y_T   = (CNT_W + 1)'(YELLOW_T);
  localparam logic [CNT_W:0] AR_T  = (CNT_W + 1)'(ALLRED_T);
  localparam logic [CNT_W:0] ONE   = (CNT_W + 1)'(1);

  phaseState_t      state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [1:0]       phaseReg, phaseNext;
  logic [3:0]       pend, pendNext;
  logic [3:0]       redLamp, yellowLamp, greenLamp;
  logic [3:0]       redNext, yellowNext, greenNext;
  logic             greenStart, greenStartNext;

  logic             tickQ;
  logic [CNT_W:0]   g;
  logic [3:0]       phaseMask, nextMask;
  logic             others;
  logic [1:0]       pick, cand;
  logic             found;

  always_comb begin
    tickQ     = EN & TICK;
    g         = {1'b0, cnt} + ONE;
    phaseMask = 4'b0001 << phaseReg;
    others    = |(pend & ~phaseMask);

    // Round-robin scan starting after the last-served approach, itself last.
    pick  = phaseReg + 2'd1;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = phaseReg + 2'(k);
      if (!found && pend[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end

    stateNext = state;
    phaseNext = phaseReg;
    case (state)
      GREEN: begin
        if (tickQ && others && ((g >= G_MAX) || ((g >= G_MIN) && !REQ[phaseReg])))
          stateNext = YELLOW;
      end
      YELLOW: begin
        if (tickQ && (g >= Y_T))
          stateNext = ALLRED;
      end
      ALLRED: begin
        if (tickQ && (g >= AR_T)) begin
          stateNext = GREEN;
          phaseNext = pick;
        end
      end
      default: stateNext = ALLRED;
    endcase

    cntNext = cnt;
    if (stateNext != state)
      cntNext = '0;
    else if (tickQ && (g <= G_MAX))
      cntNext = g[CNT_W-1:0];

    // The approach holding green never latches its own request; entry-clear wins.
    pendNext = pend | (REQ & ~((state == GREEN) ? phaseMask : 4'b0000));
    greenStartNext = (stateNext == GREEN) && (state != GREEN);
    if (greenStartNext)
      pendNext[phaseNext] = 1'b0;

    nextMask   = 4'b0001 << phaseNext;
    greenNext  = (stateNext == GREEN)  ? nextMask : 4'b0000;
    yellowNext = (stateNext == YELLOW) ? nextMask : 4'b0000;
    redNext    = ~(greenNext | yellowNext);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ALLRED;
      cnt        <= '0;
      phaseReg   <= 2'd3;
      pend       <= 4'b0000;
      redLamp    <= 4'b1111;
      yellowLamp <= 4'b0000;
      greenLamp  <= 4'b0000;
      greenStart <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      phaseReg   <= phaseNext;
      pend       <= pendNext;
      redLamp    <= redNext;
      yellowLamp <= yellowNext;
      greenLamp  <= greenNext;
      greenStart <= greenStartNext;
    end
  end

  assign N_RedLight    = redLamp[0];
  assign N_YellowLight = yellowLamp[0];
  assign N_GreenLight  = greenLamp[0];
  assign E_RedLight    = redLamp[1];
  assign E_YellowLight = yellowLamp[1];
  assign E_GreenLight  = greenLamp[1];
  assign S_RedLight    = redLamp[2];
  assign S_YellowLight = yellowLamp[2];
  assign S_GreenLight  = greenLamp[2];
  assign W_RedLight    = redLamp[3];
  assign W_YellowLight = yellowLamp[3];
  assign W_GreenLight  = greenLamp[3];
  assign PHASE         = phaseReg;
  assign GREEN_START   = greenStart;
  assign STATE_DBG     = state;

endmodule

// File: tb/tb_junction_phase_sequencer.sv
// Bench for junction_phase_sequencer: expected grants (approach, tick number)
// are queued as stimulus is driven and popped on every GREEN_START pulse.
module tb_junction_phase_sequencer;

  localparam int K_GREEN  = 0;
  localparam int K_YELLOW = 1;
  localparam int K_ALLRED = 2;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       TICK;
  logic [3:0] REQ;
  logic       N_RedLight, N_YellowLight, N_GreenLight;
  logic       E_RedLight, E_YellowLight, E_GreenLight;
  logic       S_RedLight, S_YellowLight, S_GreenLight;
  logic       W_RedLight, W_YellowLight, W_GreenLight;
  logic [1:0] PHASE;
  logic       GREEN_START;
  logic [1:0] STATE_DBG;
  logic [11:0] lamps;

  logic [15:0] exp_q[$];
  int          n_checks;
  int          n_errors;
  int          tick_count;

  junction_phase_sequencer #(
    .GREEN_MIN(3),
    .GREEN_MAX(6),
    .YELLOW_T (2),
    .ALLRED_T (1),
    .CNT_W    (16)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .EN           (EN),
    .TICK         (TICK),
    .REQ          (REQ),
    .N_RedLight   (N_RedLight),
    .N_YellowLight(N_YellowLight),
    .N_GreenLight (N_GreenLight),
    .E_RedLight   (E_RedLight),
    .E_YellowLight(E_YellowLight),
    .E_GreenLight (E_GreenLight),
    .S_RedLight   (S_RedLight),
    .S_YellowLight(S_YellowLight),
    .S_GreenLight (S_GreenLight),
    .W_RedLight   (W_RedLight),
    .W_YellowLight(W_YellowLight),
    .W_GreenLight (W_GreenLight),
    .PHASE        (PHASE),
    .GREEN_START  (GREEN_START),
    .STATE_DBG    (STATE_DBG)
  );

  assign lamps = {N_RedLight, N_YellowLight, N_GreenLight,
                  E_RedLight, E_YellowLight, E_GreenLight,
                  S_RedLight, S_YellowLight, S_GreenLight,
                  W_RedLight, W_YellowLight, W_GreenLight};

  // Clock and reset defaults
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] lamp_vec(input int kind, input int ph);
    logic [11:0] v;
    logic [2:0]  t;
    v = '0;
    for (int d = 0; d < 4; d++) begin
      t = 3'b100;
      if (kind == K_GREEN && d == ph) t = 3'b001;
      else if (kind == K_YELLOW && d == ph) t = 3'b010;
      v[11-3*d -: 3] = t;
    end
    return v;
  endfunction

  // One clock; outputs sampled 1ns after the edge, then the grant monitor runs.
  task automatic step();
    logic [3:0]  okv;
    logic [15:0] e;
    @(posedge CLK);
    #1;
    if (RST_N && EN && TICK) tick_count++;
    for (int d = 0; d < 4; d++) okv[d] = $onehot(lamps[11-3*d -: 3]);
    check_eq("lamp_onehot", 32'(okv), 32'hF);
    if (GREEN_START) begin
      if (exp_q.size() == 0) begin
        check_eq("grant_unexp", 32'(GREEN_START), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("grant", {16'd0, PHASE, tick_count[13:0]}, {16'd0, e});
      end
    end
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      repeat (3) step();
      TICK = 1'b1;
      step();
      TICK = 1'b0;
    end
  endtask

  task automatic pulse_req(input logic [3:0] m);
    REQ = REQ | m;
    step();
    REQ = REQ & ~m;
  endtask

  task automatic expect_lamps(input string tag, input int kind, input int ph);
    check_eq(tag, 32'(lamps), 32'(lamp_vec(kind, ph)));
    check_eq({tag, "_state"}, 32'(STATE_DBG), 32'(kind));
    if (kind != K_ALLRED) check_eq({tag, "_phase"}, 32'(PHASE), 32'(ph));
  endtask

  task automatic expect_reset_values(input string tag);
    check_eq({tag, "_lamps"}, 32'(lamps), 32'(lamp_vec(K_ALLRED, 0)));
    check_eq({tag, "_phase"}, 32'(PHASE), 32'd3);
    check_eq({tag, "_gs"}, 32'(GREEN_START), 32'd0);
    check_eq({tag, "_state"}, 32'(STATE_DBG), 32'(K_ALLRED));
  endtask

  task automatic do_reset(input string tag);
    check_eq({tag, "_q_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    RST_N = 1'b0;
    step();
    expect_reset_values(tag);
    RST_N = 1'b1;
    tick_count = 0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    tick_count = 0;
    RST_N = 1'b0;
    EN    = 1'b1;
    TICK  = 1'b0;
    REQ   = 4'b0000;
    repeat (2) step();
    expect_reset_values("rst");
    RST_N = 1'b1;
    tick_count = 0;

    // No requests: first tick grants North, which then rests.
    exp_q.push_back({2'd0, 14'd1});
    run_ticks(1);
    expect_lamps("t1_ngreen", K_GREEN, 0);
    run_ticks(100);
    expect_lamps("t1_nhold", K_GREEN, 0);

    // South request during N green tick 1; East skipped.
    do_reset("t2_rst");
    exp_q.push_back({2'd0, 14'd1});
    run_ticks(2);
    pulse_req(4'b0100);
    run_ticks(1);
    expect_lamps("t2_green_t3", K_GREEN, 0);
    run_ticks(1);
    expect_lamps("t2_yellow", K_YELLOW, 0);
    run_ticks(1);
    expect_lamps("t2_yellow2", K_YELLOW, 0);
    run_ticks(1);
    expect_lamps("t2_allred", K_ALLRED, 0);
    exp_q.push_back({2'd2, 14'd7});
    run_ticks(1);
    expect_lamps("t2_sgreen", K_GREEN, 2);

    // North held high forces the max-green path.
    REQ[0] = 1'b1;
    exp_q.push_back({2'd0, 14'd13});
    run_ticks(2);
    expect_lamps("t3_s_hold", K_GREEN, 2);
    run_ticks(1);
    expect_lamps("t3_s_yellow", K_YELLOW, 2);
    run_ticks(3);
    expect_lamps("t3_ngreen", K_GREEN, 0);
    pulse_req(4'b0010);
    run_ticks(5);
    expect_lamps("t3_n_tick5", K_GREEN, 0);
    run_ticks(1);
    expect_lamps("t3_n_max", K_YELLOW, 0);
    REQ[0] = 1'b0;
    exp_q.push_back({2'd1, 14'd22});
    run_ticks(3);
    expect_lamps("t3_egreen", K_GREEN, 1);
    run_ticks(5);
    expect_lamps("t3_erest", K_GREEN, 1);

    // East and West together: E first, then W, then rest on W.
    do_reset("t4_rst");
    exp_q.push_back({2'd0, 14'd1});
    run_ticks(1);
    pulse_req(4'b1010);
    exp_q.push_back({2'd1, 14'd7});
    exp_q.push_back({2'd3, 14'd13});
    run_ticks(3);
    expect_lamps("t4_n_yellow", K_YELLOW, 0);
    run_ticks(3);
    expect_lamps("t4_egreen", K_GREEN, 1);
    run_ticks(3);
    expect_lamps("t4_e_yellow", K_YELLOW, 1);
    run_ticks(3);
    expect_lamps("t4_wgreen", K_GREEN, 3);
    run_ticks(20);
    expect_lamps("t4_wrest", K_GREEN, 3);

    // Saturated green ends on the next tick; EN low freezes yellow.
    pulse_req(4'b0001);
    run_ticks(1);
    expect_lamps("t5_w_yellow", K_YELLOW, 3);
    run_ticks(1);
    expect_lamps("t5_yellow_t1", K_YELLOW, 3);
    EN = 1'b0;
    run_ticks(5);
    expect_lamps("t5_frozen", K_YELLOW, 3);
    EN = 1'b1;
    run_ticks(1);
    expect_lamps("t5_allred", K_ALLRED, 3);
    exp_q.push_back({2'd0, 14'd37});
    run_ticks(1);
    expect_lamps("t5_ngreen", K_GREEN, 0);

    // Asynchronous reset mid-green with a pending South request.
    pulse_req(4'b0100);
    step();
    #2;
    RST_N = 1'b0;
    #1;
    expect_reset_values("t6_async");
    check_eq("t6_q_drained", 32'(exp_q.size()), 32'd0);
    tick_count = 0;
    step();
    RST_N = 1'b1;
    exp_q.push_back({2'd0, 14'd1});
    run_ticks(1);
    expect_lamps("t6_ngreen", K_GREEN, 0);
    run_ticks(8);
    expect_lamps("t6_pend_clear", K_GREEN, 0);

    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/junction_phase_sequencer.md
# junction_phase_sequencer

Actuated four-way phase sequencer for a single traffic junction. It latches vehicle presence requests from the North, East, South and West approaches and grants green to one approach at a time in round-robin order. Each grant runs green, then yellow, then all-red clearance, with timing taken from a prescaled time-base pulse. It sits upstream of the per-direction light drivers and produces registered red/yellow/green lamp commands plus phase status.

## Interface
- `GREEN_MIN`, default 10: minimum green duration, in TICKs; must be ≥1.
- `GREEN_MAX`, default 40: green duration after which green is forced to end when another approach is waiting; must be ≥ `GREEN_MIN`.
- `YELLOW_T`, default 4: yellow duration, in TICKs; must be ≥1.
- `ALLRED_T`, default 2: all-red clearance duration, in TICKs; must be ≥1.
- `CNT_W`, default 16: width of the tick counter; must hold `GREEN_MAX`.

Ports:
- `CLK` input 1: single clock; all logic is on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `EN` input 1: run enable. When low, the block holds all state and ignores TICK.
- `TICK` input 1: one-cycle time-base pulse from the prescaler.
- `REQ` input 4: vehicle presence, level-sensitive; bit0=N, bit1=E, bit2=S, bit3=W.
- `N_RedLight`, `N_YellowLight`, `N_GreenLight` output 1 each: North lamp commands, registered.
- `E_RedLight`, `E_YellowLight`, `E_GreenLight` output 1 each: East lamp commands, registered.
- `S_RedLight`, `S_YellowLight`, `S_GreenLight` output 1 each: South lamp commands, registered.
- `W_RedLight`, `W_YellowLight`, `W_GreenLight` output 1 each: West lamp commands, registered.
- `PHASE` output 2: current or last-served approach (0=N, 1=E, 2=S, 3=W).
- `GREEN_START` output 1: one-cycle pulse on the cycle green is entered.

## Operation
- The FSM has three states: GREEN, YELLOW and ALLRED. `PHASE` selects the approach that is in GREEN or YELLOW; every other approach shows red. In ALLRED, all four approaches show red.
- Exactly one lamp per approach is high at all times.
- Pending latches `pend[3:0]`:
  - A latch bit is set on any cycle where the matching `REQ[i]`=1, except for the approach currently in GREEN.
  - `pend[i]` is cleared on the edge where approach i enters GREEN. Clear wins over a simultaneous set.
  - `EN`=0 does not block latching.
- Counter `cnt`:
  - Cleared on every state entry.
  - Increments on each `TICK` while `EN`=1.
  - Saturates at `GREEN_MAX`.
- Let g = `cnt`+1 at a qualifying TICK, and let `others` = OR of `pend` excluding `PHASE`.
- GREEN → YELLOW when either condition holds:
  - g ≥ `GREEN_MAX` and `others`=1, or
  - g ≥ `GREEN_MIN` and `others`=1 and `REQ[PHASE]`=0.
- With no other pending request, GREEN rests indefinitely.
- YELLOW → ALLRED at g = `YELLOW_T`.
- ALLRED → GREEN at g = `ALLRED_T`. The next approach is chosen as follows:
  - Scan PHASE+1, PHASE+2, PHASE+3, then PHASE (mod 4) and take the first with `pend` set.
  - If none is set, take PHASE+1.
  - `PHASE` updates on that same edge.
- Reset state:
  - State is ALLRED and `cnt`=0.
  - `PHASE`=3, so North is the first candidate.
  - `pend`=0.
  - All `*_RedLight`=1; all yellow and green lamps=0.
  - `GREEN_START`=0.

## Timing
- Lamp outputs, `PHASE` and `GREEN_START` are registered and change on the same edge as the state register, with no extra pipeline stage.
- A state lasts exactly T qualifying TICKs. The transition occurs on the edge that samples the T-th TICK.
- A `REQ` sampled on edge k is visible in `pend` after edge k. It can influence a decision on a TICK at edge k+1 or later.
- `TICK` while `EN`=0 is lost, not deferred.
- `RST_N` low forces reset values immediately, regardless of `CLK`. Deassertion is synchronised externally. After deassertion, the first qualifying TICK is ALLRED tick 1.
- `REQ` changing on the same edge as a TICK uses the sampled value for that edge.

## Test plan
Parameters: `GREEN_MIN`=3, `GREEN_MAX`=6, `YELLOW_T`=2, `ALLRED_T`=1. `TICK` every 4 cycles. `EN`=1.
- Reset, no `REQ` → first TICK enters N green with a `GREEN_START` pulse and `PHASE`=0. N green holds for 100 TICKs; all others stay red.
- During N green at tick 1, pulse `REQ[2]` for 1 cycle → green ends on tick 3, then 2 TICKs yellow, 1 TICK all-red, then S green with `PHASE`=2 (E skipped).
- `REQ[0]` held high, pulse `REQ[1]` → N green lasts exactly 6 TICKs before yellow, then E green.
- Pulse `REQ[1]` and `REQ[3]` in the same cycle during N green → E served, then W, then rest on W green.
- `EN`=0 for 20 cycles mid-yellow (5 TICKs lost) → lamps and `cnt` frozen; after `EN`=1, exactly 1 more TICK of yellow remains.
- `RST_N` pulsed low mid-green with `pend`≠0 → all red immediately with no `CLK` edge; `PHASE`=3 and `pend`=0 afterwards.
